mul_share_arbiter: RTL

Round-robin sequencer that shares one combinational 4x4 array multiplier among NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the multiplier's 8-bit operand bus from a register. It captures the 8-bit product one cycle later and returns it, tagged with the requester index, over a valid/ready response channel. It sits between the requester-side logic and the multiplier instance, which it drives through `mul_operands` and `mul_product`.

---
 rtl/mul_share_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Round-robin sequencer that time-shares one external combinational 4x4
// multiplier among NREQ requesters. One operation is in flight at a time:
// accept (IDLE) -> drive operands (EXEC) -> hold response (RESP).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       per-requester request
//   req_data        requester i operands at [8i+7:8i], packed {q, m}
//   req_ready       one-hot grant (combinational), IDLE only
//   mul_operands    registered operand bus to the multiplier
//   mul_product     combinational product from the multiplier
//   rsp_valid       response available
//   rsp_id          index of the requester that owns the response
//   rsp_product     captured product m*q
//   rsp_ready       response consumer ready
//   busy            high in any state other than IDLE
//   ops_done        wrapping count of completed response handshakes
module mul_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          mul_operands,
    input  logic [7:0]          mul_product,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_product,
    input  logic                rsp_ready,
    output logic                busy,
    output logic [15:0]         ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   r_id;
    logic [7:0]       r_op;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [7:0]       r_rsp_product;
    logic             r_busy;
    logic [15:0]      r_ops_done;

    logic             w_found;
    logic [IDW-1:0]   w_sel;
    int unsigned      w_idx;
    logic [NREQ-1:0]  w_grant;
    logic             w_accept;

    // Round-robin search starting just after the last grant; the modulo keeps
    // the search inside 0..NREQ-1 when NREQ is not a power of two.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = (32'(r_last_grant) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = IDW'(w_idx);
            end
        end
    end

    // Grant only in IDLE and never while reset is asserted.
    always_comb begin
        w_grant = '0;
        if (!rst && (r_state == S_IDLE) && w_found) begin
            w_grant = NREQ'(1) << w_sel;
        end
    end

    assign w_accept = |(req_valid & w_grant);

    // Sequencer: state, captured operands, response registers and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= IDW'(NREQ - 1);
            r_id          <= '0;
            r_op          <= 8'h00;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= 8'h00;
            r_busy        <= 1'b0;
            r_ops_done    <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op         <= req_data[8*w_sel +: 8];
                        r_id         <= w_sel;
                        r_last_grant <= w_sel;
                        r_state      <= S_EXEC;
                        r_busy       <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // Multiplier has settled on r_op by the end of this cycle.
                    r_rsp_product <= mul_product;
                    r_rsp_id      <= r_id;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 16'd1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = w_grant;
    assign mul_operands = r_op;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_product  = r_rsp_product;
    assign busy         = r_busy;
    assign ops_done     = r_ops_done;

endmodule
